// File: rtl/sa_output_drain.sv
// -----------------------------------------------------------------------------
// sa_output_drain
//
// Takes a snapshot of the systolic array's accumulator matrix when y_valid
// pulses, then streams it out one row per beat, requantising each 2*WIDTH
// accumulator to a saturated WIDTH-bit value (round-half-up, then clamp).
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid never drops while a row is pending, and out_data / out_row /
// out_last hold stable until that row is accepted.
//
// Ports
//   clock      : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   Y_in       : accumulator matrix [HIDDEN_SIZE][CONTEXT_LENGTH] of 2*WIDTH
//   y_valid    : one-cycle pulse, Y_in holds final results
//   shift_amt  : requantisation right-shift, sampled with y_valid
//   out_data   : one requantised row, CONTEXT_LENGTH x WIDTH signed
//   out_row    : row index of out_data
//   out_valid  : out_data / out_row / out_last are valid
//   out_ready  : consumer accepts the beat
//   out_last   : high while the final row is presented
//   busy       : a snapshot is held and not yet fully drained; this is also
//                the FSM state made visible (1 = DRAIN, 0 = IDLE)
//   drop_err   : sticky, a y_valid arrived while it could not be taken
// -----------------------------------------------------------------------------
module sa_output_drain #(
   parameter int WIDTH          = 16,
   parameter int HIDDEN_SIZE    = 64,
   parameter int CONTEXT_LENGTH = 128
) (
   input  logic                                                      clock,
   input  logic                                                      rst,
   input  logic signed [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][2*WIDTH-1:0] Y_in,
   input  logic                                                      y_valid,
   input  logic [4:0]                                                shift_amt,
   output logic signed [CONTEXT_LENGTH-1:0][WIDTH-1:0]               out_data,
   output logic [$clog2(HIDDEN_SIZE)-1:0]                            out_row,
   output logic                                                      out_valid,
   input  logic                                                      out_ready,
   output logic                                                      out_last,
   output logic                                                      busy,
   output logic                                                      drop_err
);

   localparam int RW = $clog2(HIDDEN_SIZE);
   localparam int AW = 2*WIDTH + 1;   // one guard bit so the rounding add cannot wrap

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t                                                state;
   logic [RW-1:0]                                         row_cnt;
   logic [4:0]                                            shift_q;
   logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][2*WIDTH-1:0] snap;
   logic [CONTEXT_LENGTH-1:0][2*WIDTH-1:0]                row_sel;

   logic beat_xfer;
   logic last_row;
   logic capture;

   // Round-half-up arithmetic shift followed by saturation to WIDTH bits.
   function automatic logic [WIDTH-1:0] requant(input logic signed [2*WIDTH-1:0] v,
                                                input logic [4:0]                 s);
      logic signed [AW-1:0] ext;
      logic signed [AW-1:0] rnd;
      logic signed [AW-1:0] r;
      logic [WIDTH-1:0]     res;
      ext = v;
      rnd = '0;
      if (s != 5'd0) begin
         rnd = AW'(1) << (s - 5'd1);
      end
      r = (ext + rnd) >>> s;
      // In range exactly when every bit from the WIDTH-1 sign position up agrees.
      if ((r[AW-1:WIDTH-1] == '0) || (r[AW-1:WIDTH-1] == '1)) begin
         res = r[WIDTH-1:0];
      end else if (r[AW-1]) begin
         res = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         res = {1'b0, {(WIDTH-1){1'b1}}};
      end
      return res;
   endfunction

   assign out_valid = (state == S_DRAIN);
   assign busy      = (state == S_DRAIN);
   assign last_row  = (row_cnt == RW'(HIDDEN_SIZE-1));
   assign beat_xfer = out_valid && out_ready;
   assign out_last  = out_valid && last_row;
   assign out_row   = out_valid ? row_cnt : '0;

   // A new snapshot is taken from IDLE, or on the very edge the final row
   // leaves, so back-to-back matrices stream without a bubble.
   assign capture = y_valid && ((state == S_IDLE) || (beat_xfer && last_row));

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         row_cnt  <= '0;
         shift_q  <= '0;
         drop_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (y_valid) begin
                  state   <= S_DRAIN;
                  row_cnt <= '0;
                  shift_q <= shift_amt;
               end
            end
            S_DRAIN: begin
               if (beat_xfer) begin
                  if (last_row) begin
                     row_cnt <= '0;
                     if (y_valid) begin
                        shift_q <= shift_amt;
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
               if (y_valid && !(beat_xfer && last_row)) begin
                  drop_err <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Snapshot storage carries no reset; it is only read while in DRAIN,
   // which is only reachable through a capture.
   always_ff @(posedge clock) begin
      if (capture) begin
         snap <= Y_in;
      end
   end

   assign row_sel = snap[row_cnt];

   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int c = 0; c < CONTEXT_LENGTH; c++) begin
            out_data[c] = requant(row_sel[c], shift_q);
         end
      end
   end

endmodule

// File: doc/sa_output_drain.md
SA_OUTPUT_DRAIN -- requirements
Module: sa_output_drain

Interface
REQ-001 Parameter WIDTH, default 16, is the signed element width of output data; the accumulator width is 2*WIDTH.
REQ-002 Parameter HIDDEN_SIZE, default 64, is the number of accumulator rows, one row per output beat.
REQ-003 Parameter CONTEXT_LENGTH, default 128, is the number of elements per row.
REQ-004 clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 Y_in  input  signed [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][2*WIDTH-1:0]  accumulator matrix from the systolic array.
REQ-007 y_valid  input  1  single-cycle pulse: Y_in holds final results this cycle.
REQ-008 shift_amt  input  5  right-shift for requantization, sampled with y_valid.
REQ-009 out_data  output  signed [CONTEXT_LENGTH-1:0][WIDTH-1:0]  one requantized row.
REQ-010 out_row  output  $clog2(HIDDEN_SIZE)  row index of out_data.
REQ-011 out_valid  output  1  out_data, out_row and out_last are valid.
REQ-012 out_ready  input  1  consumer accepts the beat.
REQ-013 out_last  output  1  high with row HIDDEN_SIZE-1.
REQ-014 busy  output  1  a snapshot is held and not yet fully drained.
REQ-015 drop_err  output  1  sticky flag: a y_valid was dropped.

Function
REQ-016 The block shall implement two states: IDLE (busy=0, out_valid=0) and DRAIN (busy=1, out_valid=1).
REQ-017 In IDLE, y_valid=1 shall copy Y_in into an internal snapshot, latch shift_amt, set the row counter to 0 and enter DRAIN on the same edge.
REQ-018 Latency shall be one cycle: y_valid sampled at edge t produces out_valid=1 with out_row=0 after edge t.
REQ-019 A beat shall transfer on any edge where out_valid && out_ready; only then shall the row counter increment.
REQ-020 While out_valid && !out_ready, out_data, out_row and out_last shall hold stable.
REQ-021 out_last shall equal (out_row == HIDDEN_SIZE-1) while out_valid=1, and 0 otherwise.
REQ-022 The transfer of the last beat shall return to IDLE unless y_valid=1 on the same edge; in that case the new snapshot shall be captured, the row counter set to 0, and the block shall stay in DRAIN with no bubble.
REQ-023 A y_valid in DRAIN that is not on the last-beat transfer edge shall be ignored, shall leave the snapshot unchanged, and shall set drop_err=1.
REQ-024 Requantization of each element v (2*WIDTH signed) shall be performed as follows. If the latched shift s is 0, r=v. If s>0, r=(v + 2^(s-1)) >>> s, computed in 2*WIDTH+1 bits so the rounding add cannot wrap.
REQ-025 r shall saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] to form out_data[c].
REQ-026 out_data shall be driven from registered state or pure combinational logic of the snapshot row, the row counter and the latched shift; it shall never depend on live Y_in in DRAIN.
REQ-027 In IDLE, out_data shall be 0 and out_row shall be 0.
REQ-028 The row counter shall not wrap past HIDDEN_SIZE-1 without a state change.

Reset
REQ-029 Asserting rst low shall immediately force the following: state=IDLE, out_valid=0, out_last=0, busy=0, drop_err=0, out_row=0, out_data=0, row counter=0, latched shift=0.
REQ-030 The snapshot contents shall need no reset.
REQ-031 Reset asserted mid-drain shall discard the remaining rows; no beat shall be emitted after reset deassertion until a new y_valid arrives.
REQ-032 drop_err shall clear only on reset.

Verification
REQ-033 Basic drain: Y_in[h][c]=h*256+c, shift_amt=8, out_ready=1 -> 64 consecutive beats with out_row 0..63, out_data[c]=h (rounded), out_last only on row 63; busy falls after the 64th beat.
REQ-034 Rounding and saturation: element values +383, -385 and 0x7FFF_FFFF with shift_amt=8 -> +1, -2 and 32767. Value -2^31 with shift 0 -> -32768.
REQ-035 Backpressure: out_ready toggles 1,0,0,1 at random -> each row appears exactly once, in order. Outputs hold during stalls and the total beat count is 64.
REQ-036 Back-to-back: a second y_valid on the edge where row 63 is accepted -> next cycle shows out_row=0 of the new snapshot, busy stays 1 and drop_err stays 0.
REQ-037 Dropped capture: y_valid asserted while out_row=10 -> drain continues unchanged from the original data and drop_err=1 until reset.
REQ-038 Async reset mid-drain: rst low at out_row=20, between clock edges -> out_valid=0 and busy=0 immediately. After release, no beats appear until a new y_valid.
